pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Fetch-side consumer of the control-hazard `kill` signal. It owns the program counter and a return-address stack, and selects the next PC from the opcode in the decode stage. It also drives the IF/ID pipeline register, turning the fetched instruction into a bubble whenever decode redirects control flow. It sits between instruction memory and the decode stage, and takes `kill` from the hazard unit in the same cycle it is produced.

## Interface
- `ADDR_W`, 16: PC and target width; PC is word-addressed.
- `RAS_DEPTH`, 8: number of return-address stack entries; power of two, at least 2.
- `RESET_PC`, 16'h0000: PC value after reset and the redirect target on stack underflow.

- `clk` in 1: single clock, all state on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: load-use stall; holds PC, stack and IF/ID.
- `kill` in 1: redirect request from the hazard unit.
- `op_id` in 4: opcode of the instruction in decode.
- `pc_id` in ADDR_W: PC of the instruction in decode.
- `branch_target` in ADDR_W: resolved BEQ/BNE target.
- `jump_target` in ADDR_W: JMP/CALL target.
- `for_target` in ADDR_W: FOR loop-back target.
- `imem_data` in 16: instruction word at `pc`, combinational read.
- `pc` out ADDR_W: current fetch address.
- `if_id_instr` out 16: IF/ID instruction; 16'h0000 is the NOP/bubble.
- `if_id_pc` out ADDR_W: IF/ID PC.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `ras_count` out $clog2(RAS_DEPTH)+1: live stack entries.
- `ras_overflow` out 1: sticky; a push occurred while the stack was full.
- `ras_underflow` out 1: sticky; a pop occurred while the stack was empty.

## Operation
- Effective redirect: `redir = kill & ~stall`. `kill` is ignored while `stall`=1, because forwarded operands are not yet valid.
- Next-PC priority, evaluated at each edge:
  1. `reset`
  2. `stall`: hold
  3. `redir`: target selected by `op_id`
  4. otherwise `pc+1`
- Redirect targets by `op_id`:
  - BEQ, BNE: `branch_target`
  - JMP, CALL: `jump_target`
  - FOR: `for_target`
  - RET: stack top; if `ras_count`=0, `RESET_PC`
  - Any other opcode with `redir`: `pc+1`. No IF/ID flush, stack untouched.
- Return-address stack, changed only on `redir`:
  - CALL pushes `pc_id+1` (mod 2^ADDR_W).
  - RET pops.
  - Push when full: circular overwrite of the oldest entry, `ras_count` stays at RAS_DEPTH, set `ras_overflow`.
  - Pop when empty: `ras_count` stays 0, set `ras_underflow`, target is `RESET_PC`.
- IF/ID update:
  - Normal: `if_id_instr<=imem_data`, `if_id_pc<=pc`, `if_id_valid<=1`.
  - `redir` for BEQ/BNE/JMP/CALL/RET/FOR: `if_id_instr<=16'h0000`, `if_id_valid<=0`, `if_id_pc<=pc`. This flushes the wrong-path instruction.
  - `stall`: all IF/ID fields hold.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 wraps to 16'h0000.
- Sticky flags clear only on `reset`.

## Timing
- Reset values:
  - `pc`=RESET_PC
  - `if_id_instr`=16'h0000, `if_id_pc`=16'h0000, `if_id_valid`=0
  - `ras_count`=0, `ras_overflow`=0, `ras_underflow`=0
  - Stack entries are don't-care.
- Reset asserted mid-operation wins over `stall` and `kill` in the same cycle.
- Redirect latency: `kill` high in cycle N, so `pc`=target after edge N+1. The instruction fetched in cycle N becomes exactly one bubble.
- Stack push/pop takes effect at the same edge as the redirect. A RET on the cycle directly after a CALL pops the just-pushed value, so no bypass is needed.
- `kill` and `stall` together: the cycle behaves as pure stall. The redirect happens in the first non-stalled cycle, provided `kill` is still asserted then.
- Back-to-back redirects in consecutive cycles are legal. Each one is taken.

## Test plan
- Reset then 4 free-running cycles with `imem_data`=16'h1234: `pc` steps 0,1,2,3,4; `if_id_valid`=1 from cycle 2 with `if_id_pc` lagging `pc` by 1.
- BEQ in decode, `kill`=1, `branch_target`=16'h0040, `pc`=16'h0010: next `pc`=16'h0040, `if_id_instr`=16'h0000, `if_id_valid`=0.
- CALL at `pc_id`=16'h0020 to 16'h0100, then RET: `ras_count` goes 1 then 0; after RET, `pc`=16'h0021.
- 9 CALLs with RAS_DEPTH=8: `ras_overflow`=1, `ras_count`=8. Then 8 RETs return the 8 most recent return addresses in LIFO order. A further RET sets `ras_underflow` and gives `pc`=RESET_PC.
- `stall`=1 with `kill`=1 for 2 cycles, then `stall`=0 with `kill`=1 and JMP to 16'h0200: `pc` and IF/ID frozen for both stalled cycles, then `pc`=16'h0200.
- `pc`=16'hFFFF with no redirect: next `pc`=16'h0000. `reset` asserted during a `kill` cycle: all outputs take their reset values.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch stage: program counter, return-address stack and IF/ID register.
// Redirects come from the hazard unit's kill, decoded by the opcode in decode.
module pc_fetch_unit #(
    parameter int unsigned          ADDR_W    = 16,
    parameter int unsigned          RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          kill,
    input  logic [3:0]                    op_id,
    input  logic [ADDR_W-1:0]             pc_id,
    input  logic [ADDR_W-1:0]             branch_target,
    input  logic [ADDR_W-1:0]             jump_target,
    input  logic [ADDR_W-1:0]             for_target,
    input  logic [15:0]                   imem_data,
    output logic [ADDR_W-1:0]             pc,
    output logic [15:0]                   if_id_instr,
    output logic [ADDR_W-1:0]             if_id_pc,
    output logic                          if_id_valid,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_overflow,
    output logic                          ras_underflow
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    // Control-flow opcode encoding shared with decode.
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_BNE  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_CALL = 4'h7;
    localparam logic [3:0] OP_RET  = 4'h8;
    localparam logic [3:0] OP_FOR  = 4'h9;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]     sp;
    logic              redir;
    logic              flush;
    logic              ras_empty;
    logic              ras_full;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] target;

    always_comb begin
        redir     = kill & ~stall;
        pc_inc    = pc + ADDR_W'(1);
        ras_empty = (ras_count == '0);
        ras_full  = (ras_count == CW'(RAS_DEPTH));
        ras_top   = ras_mem[sp - PW'(1)];
        flush     = 1'b1;
        target    = pc_inc;
        unique case (op_id)
            OP_BEQ, OP_BNE:  target = branch_target;
            OP_JMP, OP_CALL: target = jump_target;
            OP_FOR:          target = for_target;
            OP_RET:          target = ras_empty ? RESET_PC : ras_top;
            default:         flush  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_id_instr <= 16'h0000;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            pc       <= redir ? target : pc_inc;
            if_id_pc <= pc;
            if (redir && flush) begin
                if_id_instr <= 16'h0000;
                if_id_valid <= 1'b0;
            end else begin
                if_id_instr <= imem_data;
                if_id_valid <= 1'b1;
            end
        end
    end

    // sp is the next free slot; when full it also points at the oldest entry,
    // so a push overwrites it circularly.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp            <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (redir && op_id == OP_CALL) begin
            sp <= sp + PW'(1);
            if (ras_full) ras_overflow <= 1'b1;
            else          ras_count    <= ras_count + CW'(1);
        end else if (redir && op_id == OP_RET) begin
            if (ras_empty) begin
                ras_underflow <= 1'b1;
            end else begin
                sp        <= sp - PW'(1);
                ras_count <= ras_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && redir && op_id == OP_CALL) begin
            ras_mem[sp] <= pc_id + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus random
// traffic compared every cycle against a queue-based behavioural model.
module tb_pc_fetch_unit;
    localparam int DEPTH = 8;
    localparam logic [15:0] RPC = 16'h0000;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_BNE  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_CALL = 4'h7;
    localparam logic [3:0] OP_RET  = 4'h8;
    localparam logic [3:0] OP_FOR  = 4'h9;

    logic        clk = 1'b0;
    logic        reset, stall, kill;
    logic [3:0]  op_id;
    logic [15:0] pc_id, branch_target, jump_target, for_target, imem_data;
    logic [15:0] pc, if_id_instr, if_id_pc;
    logic        if_id_valid, ras_overflow, ras_underflow;
    logic [3:0]  ras_count;

    pc_fetch_unit #(.ADDR_W(16), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .kill(kill), .op_id(op_id),
        .pc_id(pc_id), .branch_target(branch_target), .jump_target(jump_target),
        .for_target(for_target), .imem_data(imem_data), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [15:0] m_pc, m_instr, m_ifpc;
    logic        m_valid, m_ovf, m_unf;
    logic [15:0] m_ras[$];
    bit          fixed_imem = 1'b0;
    logic [15:0] fixed_word = 16'h0000;

    function automatic logic [15:0] imem_fn(logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [15:0] tgt;
        bit          ctl;
        if (reset) begin
            m_pc = RPC; m_instr = 16'h0000; m_ifpc = 16'h0000; m_valid = 1'b0;
            m_ovf = 1'b0; m_unf = 1'b0; m_ras.delete();
        end else if (!stall) begin
            tgt = m_pc + 16'd1;
            ctl = 1'b0;
            if (kill) begin
                ctl = 1'b1;
                case (op_id)
                    OP_BEQ, OP_BNE: tgt = branch_target;
                    OP_JMP:         tgt = jump_target;
                    OP_FOR:         tgt = for_target;
                    OP_CALL: begin
                        tgt = jump_target;
                        m_ras.push_back(pc_id + 16'd1);
                        if (m_ras.size() > DEPTH) begin
                            void'(m_ras.pop_front());
                            m_ovf = 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (m_ras.size() == 0) begin
                            tgt = RPC;
                            m_unf = 1'b1;
                        end else begin
                            tgt = m_ras.pop_back();
                        end
                    end
                    default: ctl = 1'b0;
                endcase
            end
            m_ifpc  = m_pc;
            m_instr = ctl ? 16'h0000 : imem_data;
            m_valid = !ctl;
            m_pc    = tgt;
        end
    endtask

    task automatic compare_all();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("if_id_instr", 32'(if_id_instr), 32'(m_instr));
        chk("if_id_pc", 32'(if_id_pc), 32'(m_ifpc));
        chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
        chk("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
        chk("ras_underflow", 32'(ras_underflow), 32'(m_unf));
    endtask

    task automatic cycle();
        imem_data = fixed_imem ? fixed_word : imem_fn(m_pc);
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; kill = 1'b0; op_id = 4'h0;
    endtask

    task automatic redirect(logic [3:0] op, logic [15:0] tgt);
        idle();
        kill = 1'b1; op_id = op;
        branch_target = tgt; jump_target = tgt; for_target = tgt;
        cycle();
        kill = 1'b0;
    endtask

    initial begin
        m_pc = '0; m_instr = '0; m_ifpc = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
        idle();
        pc_id = 16'h0000; branch_target = '0; jump_target = '0; for_target = '0;
        reset = 1'b1;
        cycle();
        chk("reset_pc", 32'(pc), 32'h0);
        chk("reset_valid", 32'(if_id_valid), 32'h0);

        // Free run with a fixed instruction word
        fixed_imem = 1'b1; fixed_word = 16'h1234;
        idle();
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("run_pc", 32'(pc), 32'(k));
            chk("run_ifpc", 32'(if_id_pc), 32'(k - 1));
            chk("run_instr", 32'(if_id_instr), 32'h1234);
        end
        fixed_imem = 1'b0;

        redirect(OP_JMP, 16'h0010);
        chk("jmp_pc", 32'(pc), 32'h0010);
        redirect(OP_BEQ, 16'h0040);
        chk("beq_pc", 32'(pc), 32'h0040);
        chk("beq_bubble", 32'(if_id_instr), 32'h0);
        chk("beq_valid", 32'(if_id_valid), 32'h0);

        pc_id = 16'h0020;
        redirect(OP_CALL, 16'h0100);
        chk("call_cnt", 32'(ras_count), 32'h1);
        chk("call_pc", 32'(pc), 32'h0100);
        redirect(OP_RET, 16'h0777);
        chk("ret_cnt", 32'(ras_count), 32'h0);
        chk("ret_pc", 32'(pc), 32'h0021);

        for (int i = 0; i < 9; i++) begin
            pc_id = 16'h0030 + 16'(i);
            redirect(OP_CALL, 16'h0500);
        end
        chk("ovf_flag", 32'(ras_overflow), 32'h1);
        chk("ovf_cnt", 32'(ras_count), 32'h8);
        for (int i = 8; i >= 1; i--) begin
            redirect(OP_RET, 16'h0777);
            chk("lifo_pc", 32'(pc), 32'(16'h0031 + 16'(i)));
        end
        redirect(OP_RET, 16'h0777);
        chk("unf_flag", 32'(ras_underflow), 32'h1);
        chk("unf_pc", 32'(pc), 32'(RPC));

        idle();
        stall = 1'b1; kill = 1'b1; op_id = OP_JMP; jump_target = 16'h0200;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("stall_pc", 32'(pc), 32'(RPC));
            chk("stall_valid", 32'(if_id_valid), 32'h0);
        end
        stall = 1'b0;
        cycle();
        chk("post_stall_pc", 32'(pc), 32'h0200);

        redirect(OP_JMP, 16'hFFFF);
        idle();
        cycle();
        chk("wrap_pc", 32'(pc), 32'h0000);

        reset = 1'b1; kill = 1'b1; op_id = OP_JMP; jump_target = 16'h0300;
        cycle();
        chk("rst_kill_pc", 32'(pc), 32'(RPC));
        chk("rst_kill_ovf", 32'(ras_overflow), 32'h0);
        chk("rst_kill_cnt", 32'(ras_count), 32'h0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            stall = ($urandom_range(0, 4) == 0);
            kill  = ($urandom_range(0, 9) < 4);
            op_id = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(4, 9));
            pc_id = 16'($urandom);
            branch_target = 16'($urandom);
            jump_target   = 16'($urandom);
            for_target    = 16'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
